// File: rtl/pagerank_pkg.sv
// Shared types and fixed-point helpers for the PageRank engine.
// Used by pagerank_fx_engine (optional dangling-node feature: PAGERANK_DANGLING_EN).
package pagerank_pkg;

  localparam int PKG_RANK_W = 32;

  typedef logic [PKG_RANK_W-1:0] rank_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    DIV     = 3'd2,
    SCATTER = 3'd3,
    APPLY   = 3'd4,
    CHECK   = 3'd5,
    DONE    = 3'd6
  } state_t;

  function automatic logic [63:0] fx_one(input int frac_w);
    return 64'd1 << frac_w;
  endfunction

  // Unsigned add clamped to the all-ones value of a w-bit word.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int w);
    logic [63:0] lim;
    logic [63:0] sum;
    lim = (64'd1 << w) - 64'd1;
    sum = a + b;
    return (sum > lim) ? lim : sum;
  endfunction

endpackage

// File: rtl/pagerank_seq_divider.sv
// Restoring shift-subtract divider: quotient and done appear W+1 cycles after start.
module pagerank_seq_divider #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem_r;
  logic [W-1:0]  dvs_r;
  logic [CW-1:0] cnt_r;
  logic          active_r;
  logic [W:0]    shifted_s;
  logic [W:0]    trial_s;

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    shifted_s = {rem_r, quotient[W-1]};
    trial_s   = shifted_s - {1'b0, dvs_r};
  end

  // One quotient bit per cycle; the borrow bit selects restore or keep.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rem_r    <= '0;
      dvs_r    <= '0;
      cnt_r    <= '0;
      active_r <= 1'b0;
      done     <= 1'b0;
      quotient <= '0;
    end else if (start) begin
      rem_r    <= '0;
      dvs_r    <= divisor;
      quotient <= dividend;
      cnt_r    <= CW'(W);
      active_r <= 1'b1;
      done     <= 1'b0;
    end else if (active_r) begin
      quotient <= {quotient[W-2:0], ~trial_s[W]};
      rem_r    <= trial_s[W] ? shifted_s[W-1:0] : trial_s[W-1:0];
      cnt_r    <= cnt_r - CW'(1);
      if (cnt_r == CW'(1)) begin
        active_r <= 1'b0;
        done     <= 1'b1;
      end else begin
        done     <= 1'b0;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/pagerank_fx_engine.sv
// Fixed-point PageRank engine: scatter rank/out_degree, damp, iterate to convergence.
// Optional macro PAGERANK_DANGLING_EN redistributes rank of zero-out-degree nodes.
module pagerank_fx_engine
  import pagerank_pkg::*;
#(
  parameter int NUM_PARTITIONS      = 1,
  parameter int NODES_PER_PARTITION = 4,
  parameter int NUM_NODES           = 4,
  parameter int MAX_OUT_DEGREE      = 3,
  parameter int ID_W                = 32,
  parameter int RANK_W              = 32,
  parameter int FRAC_W              = 16,
  parameter int MAX_ITER            = 64
) (
  input  logic clock,
  input  logic reset_n,
  input  logic pagerank_enable,
  input  logic [NUM_PARTITIONS-1:0][NODES_PER_PARTITION-1:0][ID_W-1:0] source_id,
  input  logic [NUM_PARTITIONS-1:0][NODES_PER_PARTITION-1:0][ID_W-1:0] out_degree,
  input  logic [NUM_PARTITIONS-1:0][NODES_PER_PARTITION-1:0][MAX_OUT_DEGREE-1:0][ID_W-1:0] dest_id,
  input  logic [RANK_W-1:0] damping_factor,
  input  logic [RANK_W-1:0] threshold,
  output logic [NUM_NODES-1:0][RANK_W-1:0] pagerank,
  output logic pagerank_complete,
  output logic converged,
  output logic busy,
  output logic [$clog2(MAX_ITER+1)-1:0] iteration_count
);

  localparam int NREC   = NUM_PARTITIONS * NODES_PER_PARTITION;
  localparam int REC_W  = (NREC > 1) ? $clog2(NREC) : 1;
  localparam int SLOT_W = (MAX_OUT_DEGREE > 1) ? $clog2(MAX_OUT_DEGREE) : 1;
  localparam int NODE_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam int IT_W   = $clog2(MAX_ITER + 1);
  localparam int PW     = 2 * RANK_W;
  localparam logic [RANK_W-1:0] ONE   = RANK_W'(fx_one(FRAC_W));
  localparam logic [RANK_W-1:0] INV_N = RANK_W'(fx_one(FRAC_W) / 64'(NUM_NODES));

  logic [NREC-1:0][ID_W-1:0]                     src_flat_s;
  logic [NREC-1:0][ID_W-1:0]                     deg_flat_s;
  logic [NREC-1:0][MAX_OUT_DEGREE-1:0][ID_W-1:0] dst_flat_s;

  state_t            state_r;
  logic [RANK_W-1:0] rank_r [NUM_NODES];
  logic [RANK_W-1:0] acc_r  [NUM_NODES];
  logic [RANK_W-1:0] base_r;
  logic [RANK_W-1:0] contrib_r;
  logic [RANK_W-1:0] max_delta_r;
  logic [REC_W-1:0]  rec_r;
  logic [SLOT_W-1:0] slot_r;
  logic [NODE_W-1:0] node_r;
  logic              div_start_r;
  logic              div_pending_r;
`ifdef PAGERANK_DANGLING_EN
  logic [RANK_W-1:0] dangle_r;
  logic [3*RANK_W-1:0] dprod_s;
`endif

  logic [ID_W-1:0]   cur_src_s;
  logic [ID_W-1:0]   cur_deg_s;
  logic [ID_W-1:0]   cur_dst_s;
  logic [ID_W-1:0]   nslots_s;
  logic              src_ok_s;
  logic              dst_ok_s;
  logic              last_slot_s;
  logic              rec_last_s;
  logic [NODE_W-1:0] src_node_s;
  logic [NODE_W-1:0] dst_node_s;
  logic [RANK_W-1:0] cur_rank_s;
  logic [RANK_W-1:0] acc_dst_s;
  logic [RANK_W-1:0] acc_sum_s;
  logic [RANK_W-1:0] acc_node_s;
  logic [RANK_W-1:0] rank_node_s;
  logic [PW-1:0]     prod_s;
  logic [RANK_W-1:0] scaled_s;
  logic [RANK_W-1:0] new_s;
  logic [RANK_W-1:0] delta_s;
  logic [IT_W-1:0]   it_next_s;
  logic              div_done_s;
  logic [RANK_W-1:0] div_quot_s;

  assign src_flat_s  = source_id;
  assign deg_flat_s  = out_degree;
  assign dst_flat_s  = dest_id;

  assign cur_src_s   = src_flat_s[rec_r];
  assign cur_deg_s   = deg_flat_s[rec_r];
  assign cur_dst_s   = dst_flat_s[rec_r][slot_r];
  assign src_ok_s    = (cur_src_s != '0) && (cur_src_s <= ID_W'(NUM_NODES));
  assign dst_ok_s    = (cur_dst_s != '0) && (cur_dst_s <= ID_W'(NUM_NODES));
  assign src_node_s  = NODE_W'(cur_src_s - ID_W'(1));
  assign dst_node_s  = NODE_W'(cur_dst_s - ID_W'(1));
  assign nslots_s    = (cur_deg_s < ID_W'(MAX_OUT_DEGREE)) ? cur_deg_s : ID_W'(MAX_OUT_DEGREE);
  assign last_slot_s = (ID_W'(slot_r) + ID_W'(1)) >= nslots_s;
  assign rec_last_s  = (rec_r == REC_W'(NREC - 1));
  assign cur_rank_s  = rank_r[src_node_s];
  assign acc_dst_s   = acc_r[dst_node_s];
  assign acc_sum_s   = RANK_W'(sat_add(64'(acc_dst_s), 64'(contrib_r), RANK_W));
  assign acc_node_s  = acc_r[node_r];
  assign rank_node_s = rank_r[node_r];
  assign it_next_s   = iteration_count + IT_W'(1);

  // Damped rank update for the node selected in APPLY and its change.
  always_comb begin
    prod_s   = PW'(damping_factor) * PW'(acc_node_s);
    scaled_s = RANK_W'(prod_s >> FRAC_W);
    new_s    = RANK_W'(sat_add(64'(base_r), 64'(scaled_s), RANK_W));
`ifdef PAGERANK_DANGLING_EN
    dprod_s  = (3*RANK_W)'(damping_factor) * (3*RANK_W)'(dangle_r) * (3*RANK_W)'(INV_N);
    new_s    = RANK_W'(sat_add(64'(new_s), 64'(RANK_W'(dprod_s >> (2*FRAC_W))), RANK_W));
`endif
    if (new_s > rank_node_s) begin
      delta_s = new_s - rank_node_s;
    end else begin
      delta_s = rank_node_s - new_s;
    end
  end

  pagerank_seq_divider #(.W(RANK_W)) u_div (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (div_start_r),
    .dividend (cur_rank_s),
    .divisor  (RANK_W'(cur_deg_s)),
    .done     (div_done_s),
    .quotient (div_quot_s)
  );

  // Iteration control: record walk, scatter, apply, convergence check.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r           <= IDLE;
      pagerank          <= '0;
      pagerank_complete <= 1'b0;
      converged         <= 1'b0;
      busy              <= 1'b0;
      iteration_count   <= '0;
      base_r            <= '0;
      contrib_r         <= '0;
      max_delta_r       <= '0;
      rec_r             <= '0;
      slot_r            <= '0;
      node_r            <= '0;
      div_start_r       <= 1'b0;
      div_pending_r     <= 1'b0;
      for (int i = 0; i < NUM_NODES; i++) begin
        rank_r[i] <= '0;
        acc_r[i]  <= '0;
      end
`ifdef PAGERANK_DANGLING_EN
      dangle_r          <= '0;
`endif
    end else begin
      div_start_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (pagerank_enable) begin
            state_r <= INIT;
            busy    <= 1'b1;
          end
        end
        INIT: begin
          for (int i = 0; i < NUM_NODES; i++) begin
            rank_r[i] <= INV_N;
            acc_r[i]  <= '0;
          end
          base_r          <= RANK_W'((64'(ONE) - 64'(damping_factor)) / 64'(NUM_NODES));
          iteration_count <= '0;
          max_delta_r     <= '0;
          rec_r           <= '0;
          slot_r          <= '0;
          div_pending_r   <= 1'b0;
`ifdef PAGERANK_DANGLING_EN
          dangle_r        <= '0;
`endif
          state_r         <= DIV;
        end
        DIV: begin
          if (!src_ok_s || (cur_deg_s == '0)) begin
`ifdef PAGERANK_DANGLING_EN
            if (src_ok_s) begin
              dangle_r <= RANK_W'(sat_add(64'(dangle_r), 64'(cur_rank_s), RANK_W));
            end
`endif
            if (rec_last_s) begin
              node_r  <= '0;
              state_r <= APPLY;
            end else begin
              rec_r   <= rec_r + REC_W'(1);
            end
          end else if (!div_pending_r) begin
            div_start_r   <= 1'b1;
            div_pending_r <= 1'b1;
          end else if (div_done_s) begin
            contrib_r     <= div_quot_s;
            div_pending_r <= 1'b0;
            slot_r        <= '0;
            state_r       <= SCATTER;
          end
        end
        SCATTER: begin
          if (dst_ok_s) begin
            acc_r[dst_node_s] <= acc_sum_s;
          end
          if (!last_slot_s) begin
            slot_r <= slot_r + SLOT_W'(1);
          end else if (rec_last_s) begin
            node_r  <= '0;
            state_r <= APPLY;
          end else begin
            rec_r   <= rec_r + REC_W'(1);
            state_r <= DIV;
          end
        end
        APPLY: begin
          rank_r[node_r]   <= new_s;
          pagerank[node_r] <= new_s;
          acc_r[node_r]    <= '0;
          if (delta_s > max_delta_r) begin
            max_delta_r <= delta_s;
          end
          if (node_r == NODE_W'(NUM_NODES - 1)) begin
            state_r <= CHECK;
          end else begin
            node_r  <= node_r + NODE_W'(1);
          end
        end
        CHECK: begin
          iteration_count <= it_next_s;
`ifdef PAGERANK_DANGLING_EN
          dangle_r        <= '0;
`endif
          if (max_delta_r < threshold) begin
            converged         <= 1'b1;
            pagerank_complete <= 1'b1;
            busy              <= 1'b0;
            state_r           <= DONE;
          end else if (it_next_s == IT_W'(MAX_ITER)) begin
            converged         <= 1'b0;
            pagerank_complete <= 1'b1;
            busy              <= 1'b0;
            state_r           <= DONE;
          end else begin
            max_delta_r <= '0;
            rec_r       <= '0;
            slot_r      <= '0;
            state_r     <= DIV;
          end
        end
        DONE: begin
          // Level-sensitive enable: a fresh run needs enable to drop first.
          if (!pagerank_enable) begin
            pagerank_complete <= 1'b0;
            converged         <= 1'b0;
            state_r           <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pagerank_fx_engine.sv
// Self-checking bench for pagerank_fx_engine against an arithmetic PageRank model.
// Honours PAGERANK_DANGLING_EN in its model when the design is built with it.
module tb_pagerank_fx_engine;

  localparam int N   = 4;
  localparam int REC = 4;
  localparam int MO  = 3;
  localparam longint unsigned MAXV = 64'hFFFF_FFFF;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic pagerank_enable = 1'b0;
  logic [0:0][REC-1:0][31:0] source_id;
  logic [0:0][REC-1:0][31:0] out_degree;
  logic [0:0][REC-1:0][MO-1:0][31:0] dest_id;
  logic [31:0] damping_factor;
  logic [31:0] threshold;
  logic [N-1:0][31:0] pagerank, pagerank1;
  logic complete, complete1, converged, converged1, busy, busy1;
  logic [6:0] iteration_count;
  logic [0:0] iteration_count1;

  int n_vec = 0;
  int n_err = 0;

  int g_src [REC];
  int g_deg [REC];
  int g_dst [REC][MO];
  longint unsigned g_damp, g_thr;
  longint unsigned m_rank [N];
  bit m_conv;
  int m_iters;

  always #5 clock = ~clock;

  pagerank_fx_engine #(.MAX_ITER(64)) dut (
    .clock(clock), .reset_n(reset_n), .pagerank_enable(pagerank_enable),
    .source_id(source_id), .out_degree(out_degree), .dest_id(dest_id),
    .damping_factor(damping_factor), .threshold(threshold),
    .pagerank(pagerank), .pagerank_complete(complete), .converged(converged),
    .busy(busy), .iteration_count(iteration_count));

  pagerank_fx_engine #(.MAX_ITER(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .pagerank_enable(pagerank_enable),
    .source_id(source_id), .out_degree(out_degree), .dest_id(dest_id),
    .damping_factor(damping_factor), .threshold(threshold),
    .pagerank(pagerank1), .pagerank_complete(complete1), .converged(converged1),
    .busy(busy1), .iteration_count(iteration_count1));

  // Reference: plain fixed-point PageRank iteration over the record table.
  task automatic model_run(input int max_iter);
    longint unsigned acc [N];
    longint unsigned base, dsum, maxd, c, nv, d;
    base = (64'd65536 - g_damp) / N;
    for (int i = 0; i < N; i++) m_rank[i] = 64'd65536 / N;
    m_conv = 1'b0;
    m_iters = 0;
    for (int it = 1; it <= max_iter; it++) begin
      for (int i = 0; i < N; i++) acc[i] = 0;
      dsum = 0;
      maxd = 0;
      for (int r = 0; r < REC; r++) begin
        if (g_src[r] < 1 || g_src[r] > N) continue;
        if (g_deg[r] == 0) begin
`ifdef PAGERANK_DANGLING_EN
          dsum = dsum + m_rank[g_src[r]-1];
          if (dsum > MAXV) dsum = MAXV;
`endif
          continue;
        end
        c = m_rank[g_src[r]-1] / longint'(g_deg[r]);
        for (int k = 0; k < g_deg[r] && k < MO; k++) begin
          if (g_dst[r][k] >= 1 && g_dst[r][k] <= N) begin
            acc[g_dst[r][k]-1] = acc[g_dst[r][k]-1] + c;
            if (acc[g_dst[r][k]-1] > MAXV) acc[g_dst[r][k]-1] = MAXV;
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        nv = base + (((g_damp * acc[i]) >> 16) & MAXV);
        if (nv > MAXV) nv = MAXV;
`ifdef PAGERANK_DANGLING_EN
        nv = nv + (((g_damp * dsum * (64'd65536 / N)) >> 32) & MAXV);
        if (nv > MAXV) nv = MAXV;
`endif
        d = (nv > m_rank[i]) ? nv - m_rank[i] : m_rank[i] - nv;
        if (d > maxd) maxd = d;
        m_rank[i] = nv;
      end
      m_iters = it;
      if (maxd < g_thr) begin
        m_conv = 1'b1;
        break;
      end
    end
  endtask

  task automatic drive_inputs();
    for (int r = 0; r < REC; r++) begin
      source_id[0][r]  = 32'(g_src[r]);
      out_degree[0][r] = 32'(g_deg[r]);
      for (int k = 0; k < MO; k++) dest_id[0][r][k] = 32'(g_dst[r][k]);
    end
    damping_factor = 32'(g_damp);
    threshold      = 32'(g_thr);
  endtask

  task automatic paper_graph();
    int dst [REC][MO] = '{'{2, 3, 0}, '{4, 0, 0}, '{1, 2, 4}, '{3, 0, 0}};
    g_src = '{1, 2, 3, 4};
    g_deg = '{2, 1, 3, 1};
    g_dst = dst;
    g_damp = 64'd55705;
  endtask

  task automatic do_reset();
    pagerank_enable = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
  endtask

  task automatic wait_complete(input bit single, output bit timed_out);
    timed_out = 1'b1;
    for (int c = 0; c < 20000; c++) begin
      @(posedge clock);
      #1;
      if ((single ? complete1 : complete) === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic finish_run();
    @(negedge clock);
    pagerank_enable = 1'b0;
    repeat (3) @(posedge clock);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_vec++;
    if (pagerank !== '0 || complete !== 1'b0 || converged !== 1'b0 || busy !== 1'b0
        || iteration_count !== 7'd0) begin
      n_err++;
      $display("FAIL reset: pr=%h cmp=%b conv=%b busy=%b it=%0d, expected all zero",
               pagerank, complete, converged, busy, iteration_count);
    end
  endtask

  task automatic test_single_iter();
    int exp1 [N] = '{7100, 14063, 23347, 21026};
    bit to;
    int diff;
    paper_graph();
    g_thr = 64'd0;
    drive_inputs();
    model_run(1);
    @(negedge clock);
    pagerank_enable = 1'b1;
    wait_complete(1'b1, to);
    n_vec++;
    if (to) begin
      n_err++;
      $display("FAIL single_iter_timeout: complete=%b, expected 1", complete1);
    end
    for (int i = 0; i < N; i++) begin
      diff = int'(pagerank1[i]) - exp1[i];
      n_vec++;
      if (diff > 4 || diff < -4) begin
        n_err++;
        $display("FAIL single_iter_approx[%0d]: got %0d, expected %0d +-4", i, pagerank1[i], exp1[i]);
      end
      n_vec++;
      if (pagerank1[i] !== 32'(m_rank[i])) begin
        n_err++;
        $display("FAIL single_iter_exact[%0d]: got %0d, expected %0d", i, pagerank1[i], m_rank[i]);
      end
    end
    n_vec++;
    if (converged1 !== 1'b0 || iteration_count1 !== 1'b1) begin
      n_err++;
      $display("FAIL single_iter_status: conv=%b it=%0d, expected conv=0 it=1", converged1, iteration_count1);
    end
    do_reset();
  endtask

  task automatic test_converge(input string name);
    bit to;
    longint sum;
    model_run(64);
    drive_inputs();
    @(negedge clock);
    pagerank_enable = 1'b1;
    wait_complete(1'b0, to);
    n_vec++;
    if (to) begin
      n_err++;
      $display("FAIL %s_timeout: complete=%b, expected 1", name, complete);
    end
    sum = 0;
    for (int i = 0; i < N; i++) begin
      sum += longint'(pagerank[i]);
      n_vec++;
      if (pagerank[i] !== 32'(m_rank[i])) begin
        n_err++;
        $display("FAIL %s_rank[%0d]: got %0d, expected %0d", name, i, pagerank[i], m_rank[i]);
      end
    end
    n_vec++;
    if (converged !== m_conv || iteration_count !== 7'(m_iters) || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s_status: conv=%b it=%0d busy=%b, expected conv=%b it=%0d busy=0",
               name, converged, iteration_count, busy, m_conv, m_iters);
    end
    if (name == "converge") begin
      n_vec++;
      if (sum < 65536 - 128 || sum > 65536 + 16) begin
        n_err++;
        $display("FAIL converge_sum: got %0d, expected near 65536", sum);
      end
    end
  endtask

  task automatic test_dangling();
    bit to;
    longint sum;
    paper_graph();
    g_deg[3] = 0;
    g_thr = 64'd0;
    drive_inputs();
    model_run(1);
    @(negedge clock);
    pagerank_enable = 1'b1;
    wait_complete(1'b1, to);
    sum = 0;
    for (int i = 0; i < N; i++) begin
      sum += longint'(pagerank1[i]);
      n_vec++;
      if (to || pagerank1[i] !== 32'(m_rank[i])) begin
        n_err++;
        $display("FAIL dangling_rank[%0d]: got %0d, expected %0d", i, pagerank1[i], m_rank[i]);
      end
    end
    n_vec++;
`ifdef PAGERANK_DANGLING_EN
    if (sum < 65536 - 16 || sum > 65536 + 16) begin
      n_err++;
      $display("FAIL dangling_sum: got %0d, expected 65536 +-16", sum);
    end
`else
    if (sum >= 65536) begin
      n_err++;
      $display("FAIL dangling_sum: got %0d, expected below 65536", sum);
    end
`endif
    do_reset();
  endtask

  task automatic test_reset_mid_run();
    bit found;
    paper_graph();
    g_thr = 64'd1;
    drive_inputs();
    @(negedge clock);
    pagerank_enable = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clock);
      #1;
      if (iteration_count === 7'd1) begin
        found = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL midrun_iter1: iteration_count=%0d, expected 1", iteration_count);
    end
    repeat (35) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (pagerank !== '0 || complete !== 1'b0 || converged !== 1'b0 || busy !== 1'b0
        || iteration_count !== 7'd0) begin
      n_err++;
      $display("FAIL midrun_reset: pr=%h cmp=%b conv=%b busy=%b it=%0d, expected all zero",
               pagerank, complete, converged, busy, iteration_count);
    end
    pagerank_enable = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    test_converge("restart");
  endtask

  task automatic test_enable_hold();
    bit to;
    repeat (60) @(posedge clock);
    #1;
    n_vec++;
    if (complete !== 1'b1 || busy !== 1'b0 || iteration_count !== 7'(m_iters)) begin
      n_err++;
      $display("FAIL hold_no_retrigger: cmp=%b busy=%b it=%0d, expected cmp=1 busy=0 it=%0d",
               complete, busy, iteration_count, m_iters);
    end
    @(negedge clock);
    pagerank_enable = 1'b0;
    @(posedge clock);
    #1;
    n_vec++;
    if (complete !== 1'b0 || converged !== 1'b0) begin
      n_err++;
      $display("FAIL hold_drop: cmp=%b conv=%b, expected 0 0", complete, converged);
    end
    @(negedge clock);
    pagerank_enable = 1'b1;
    wait_complete(1'b0, to);
    for (int i = 0; i < N; i++) begin
      n_vec++;
      if (to || pagerank[i] !== 32'(m_rank[i])) begin
        n_err++;
        $display("FAIL hold_rerun[%0d]: got %0d, expected %0d", i, pagerank[i], m_rank[i]);
      end
    end
    finish_run();
  endtask

  task automatic test_bad_dest();
    paper_graph();
    g_dst[0] = '{2, 7, 3};
    g_deg[0] = 3;
    g_dst[1] = '{4, 0, 7};
    g_deg[1] = 3;
    g_thr = 64'd1;
    test_converge("bad_dest");
    finish_run();
  endtask

  task automatic test_random();
    for (int t = 0; t < 3; t++) begin
      for (int r = 0; r < REC; r++) begin
        g_src[r] = int'($urandom_range(4, 0));
        g_deg[r] = int'($urandom_range(4, 0));
        for (int k = 0; k < MO; k++) g_dst[r][k] = int'($urandom_range(7, 0));
      end
      g_damp = 64'($urandom_range(60000, 30000));
      g_thr  = 64'($urandom_range(3000, 100));
      test_converge("random");
      finish_run();
    end
  endtask

  initial begin
    paper_graph();
    g_thr = 64'd0;
    drive_inputs();
    test_reset();
    test_single_iter();
    paper_graph();
    g_thr = 64'd1;
    test_converge("converge");
    finish_run();
    test_dangling();
    test_reset_mid_run();
    test_enable_hold();
    test_bad_dest();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
